// File: rtl/decode_control_stage.sv
// rtl/decode_control_stage.sv - registered MIPS decode stage with load-use tracker, flush, stall and halt
package decode_pkg;
    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;
endpackage

module decode_control_stage
    import decode_pkg::*;
#(
    parameter int LOAD_LAT = 1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] instr_i,
    input  logic        instr_valid_i,
    input  logic        stall_ext_i,
    input  logic        flush_i,
    output logic        id_stall_o,
    output logic        iread_o,
    output logic        ex_valid_o,
    output logic [4:0]  rs_o,
    output logic [4:0]  rt_o,
    output logic [4:0]  rd_o,
    output logic [15:0] imm_o,
    output logic [4:0]  shamt_o,
    output aluop_t      ALUCtr,
    output logic        ExtOp,
    output logic        ALUSrc,
    output logic        MemtoReg,
    output logic        RegWr,
    output logic        Jump,
    output logic        JR,
    output logic        JumpReg,
    output logic        LUI,
    output logic        dread,
    output logic        dwrite,
    output logic [1:0]  RegDst,
    output logic [1:0]  Branch,
    output logic [1:0]  LDsel,
    output logic [1:0]  SVsel,
    output logic        illegal_o,
    output logic        halted_o
);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_LBU  = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25, OP_SB   = 6'h28, OP_SH   = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B, OP_HALT = 6'h3E;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06, FN_JR   = 6'h08, FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27, FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

    logic [5:0] opcode, funct;
    logic [4:0] f_rs, f_rt, f_rd, f_shamt;

    assign opcode  = instr_i[31:26];
    assign f_rs    = instr_i[25:21];
    assign f_rt    = instr_i[20:16];
    assign f_rd    = instr_i[15:11];
    assign f_shamt = instr_i[10:6];
    assign funct   = instr_i[5:0];

    aluop_t     d_alu;
    logic       d_extop, d_alusrc, d_memtoreg, d_regwr, d_jump, d_jr, d_jumpreg;
    logic       d_lui, d_dread, d_dwrite;
    logic [1:0] d_regdst, d_branch, d_ldsel, d_svsel;
    logic       use_rs, use_rt, is_load, is_halt, is_illegal;

    // Decode the instruction into its control bundle and source-use flags
    always_comb begin
        d_alu      = ALU_SLL;
        d_extop    = 1'b0;
        d_alusrc   = 1'b0;
        d_memtoreg = 1'b0;
        d_regwr    = 1'b0;
        d_jump     = 1'b0;
        d_jr       = 1'b0;
        d_jumpreg  = 1'b0;
        d_lui      = 1'b0;
        d_dread    = 1'b0;
        d_dwrite   = 1'b0;
        d_regdst   = 2'd0;
        d_branch   = 2'd0;
        d_ldsel    = 2'd0;
        d_svsel    = 2'd0;
        use_rs     = 1'b0;
        use_rt     = 1'b0;
        is_load    = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                d_regdst = 2'd1;
                d_regwr  = 1'b1;
                use_rs   = 1'b1;
                use_rt   = 1'b1;
                case (funct)
                    FN_SLL:  begin d_alu = ALU_SLL; use_rs = 1'b0; end
                    FN_SRL:  begin d_alu = ALU_SRL; use_rs = 1'b0; end
                    FN_SLLV: d_alu = ALU_SLL;
                    FN_SRLV: d_alu = ALU_SRL;
                    FN_JR: begin
                        d_regdst = 2'd0;
                        d_regwr  = 1'b0;
                        d_jr     = 1'b1;
                        use_rt   = 1'b0;
                    end
                    FN_ADD, FN_ADDU: d_alu = ALU_ADD;
                    FN_SUB, FN_SUBU: d_alu = ALU_SUB;
                    FN_AND:  d_alu = ALU_AND;
                    FN_OR:   d_alu = ALU_OR;
                    FN_XOR:  d_alu = ALU_XOR;
                    FN_NOR:  d_alu = ALU_NOR;
                    FN_SLT:  d_alu = ALU_SLT;
                    FN_SLTU: d_alu = ALU_SLTU;
                    default: begin
                        d_regdst   = 2'd0;
                        d_regwr    = 1'b0;
                        use_rs     = 1'b0;
                        use_rt     = 1'b0;
                        is_illegal = 1'b1;
                    end
                endcase
            end
            OP_J:   d_jump = 1'b1;
            OP_JAL: begin
                d_jump    = 1'b1;
                d_jumpreg = 1'b1;
                d_regwr   = 1'b1;
                d_regdst  = 2'd2;
            end
            OP_BEQ, OP_BNE: begin
                d_branch = (opcode == OP_BEQ) ? 2'd1 : 2'd2;
                d_extop  = 1'b1;
                d_alu    = ALU_SUB;
                use_rs   = 1'b1;
                use_rt   = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                d_extop  = 1'b1;
                d_alusrc = 1'b1;
                d_regwr  = 1'b1;
                use_rs   = 1'b1;
                d_alu    = (opcode == OP_SLTI)  ? ALU_SLT  :
                           (opcode == OP_SLTIU) ? ALU_SLTU : ALU_ADD;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                d_alusrc = 1'b1;
                d_regwr  = 1'b1;
                use_rs   = 1'b1;
                d_alu    = (opcode == OP_ANDI) ? ALU_AND :
                           (opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
            end
            OP_LUI: begin
                d_lui    = 1'b1;
                d_alusrc = 1'b1;
                d_regwr  = 1'b1;
            end
            OP_LW, OP_LBU, OP_LHU: begin
                d_extop    = 1'b1;
                d_alusrc   = 1'b1;
                d_regwr    = 1'b1;
                d_memtoreg = 1'b1;
                d_dread    = 1'b1;
                d_alu      = ALU_ADD;
                use_rs     = 1'b1;
                is_load    = 1'b1;
                d_ldsel    = (opcode == OP_LBU) ? 2'd1 : (opcode == OP_LHU) ? 2'd2 : 2'd0;
            end
            OP_SW, OP_SB, OP_SH: begin
                d_extop  = 1'b1;
                d_alusrc = 1'b1;
                d_dwrite = 1'b1;
                d_alu    = ALU_ADD;
                use_rs   = 1'b1;
                use_rt   = 1'b1;
                d_svsel  = (opcode == OP_SB) ? 2'd1 : (opcode == OP_SH) ? 2'd2 : 2'd0;
            end
            OP_HALT: is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

    // In-flight load tracker; entry 0 is the most recently issued slot
    logic       trk_v   [LOAD_LAT];
    logic [4:0] trk_dst [LOAD_LAT];
    logic       hazard;

    // A used, non-zero source that matches any in-flight load destination is a hazard
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < LOAD_LAT; i++) begin
            if (trk_v[i] && (trk_dst[i] != 5'd0) &&
                ((use_rs && (f_rs == trk_dst[i])) || (use_rt && (f_rt == trk_dst[i]))))
                hazard = 1'b1;
        end
        hazard = hazard & instr_valid_i;
    end

    logic can_issue, issue_dec, set_halt;

    assign can_issue  = ~flush_i & ~halted_o & ~hazard & instr_valid_i;
    assign issue_dec  = can_issue & ~is_halt;
    assign set_halt   = can_issue & is_halt;
    assign id_stall_o = stall_ext_i | (~flush_i & (halted_o | hazard));
    assign iread_o    = ~halted_o;

    // Age the load tracker on every non-frozen cycle; bubbles shift in an invalid slot
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < LOAD_LAT; i++) begin
                trk_v[i]   <= 1'b0;
                trk_dst[i] <= 5'd0;
            end
        end else if (!stall_ext_i) begin
            for (int i = LOAD_LAT - 1; i > 0; i--) begin
                trk_v[i]   <= trk_v[i-1];
                trk_dst[i] <= trk_dst[i-1];
            end
            trk_v[0]   <= issue_dec & is_load;
            trk_dst[0] <= f_rt;
        end
    end

    // Register the ID/EX bundle: the decode when issuing, zeros for a bubble
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ex_valid_o <= 1'b0;
            rs_o       <= 5'd0;
            rt_o       <= 5'd0;
            rd_o       <= 5'd0;
            imm_o      <= 16'd0;
            shamt_o    <= 5'd0;
            ALUCtr     <= ALU_SLL;
            ExtOp      <= 1'b0;
            ALUSrc     <= 1'b0;
            MemtoReg   <= 1'b0;
            RegWr      <= 1'b0;
            Jump       <= 1'b0;
            JR         <= 1'b0;
            JumpReg    <= 1'b0;
            LUI        <= 1'b0;
            dread      <= 1'b0;
            dwrite     <= 1'b0;
            RegDst     <= 2'd0;
            Branch     <= 2'd0;
            LDsel      <= 2'd0;
            SVsel      <= 2'd0;
            illegal_o  <= 1'b0;
            halted_o   <= 1'b0;
        end else if (!stall_ext_i) begin
            ex_valid_o <= issue_dec;
            rs_o       <= issue_dec ? f_rs : 5'd0;
            rt_o       <= issue_dec ? f_rt : 5'd0;
            rd_o       <= issue_dec ? f_rd : 5'd0;
            imm_o      <= issue_dec ? instr_i[15:0] : 16'd0;
            shamt_o    <= issue_dec ? f_shamt : 5'd0;
            ALUCtr     <= issue_dec ? d_alu : ALU_SLL;
            ExtOp      <= issue_dec & d_extop;
            ALUSrc     <= issue_dec & d_alusrc;
            MemtoReg   <= issue_dec & d_memtoreg;
            RegWr      <= issue_dec & d_regwr;
            Jump       <= issue_dec & d_jump;
            JR         <= issue_dec & d_jr;
            JumpReg    <= issue_dec & d_jumpreg;
            LUI        <= issue_dec & d_lui;
            dread      <= issue_dec & d_dread;
            dwrite     <= issue_dec & d_dwrite;
            RegDst     <= issue_dec ? d_regdst : 2'd0;
            Branch     <= issue_dec ? d_branch : 2'd0;
            LDsel      <= issue_dec ? d_ldsel : 2'd0;
            SVsel      <= issue_dec ? d_svsel : 2'd0;
            illegal_o  <= issue_dec & is_illegal;
            halted_o   <= halted_o | set_halt;
        end
    end

endmodule

// File: doc/decode_control_stage.md
# decode_control_stage

Registered instruction-decode stage for the pipelined MIPS core, sitting between the IF/ID latch and the ID/EX latch. It decodes the 32-bit instruction into the full datapath control bundle (ALU op, extend, mux selects, memory size selects, jump/branch kind) and registers it. It also inserts load-use bubbles from a parametrised in-flight-load tracker, honours branch flushes and external stalls, and latches HALT.

## Interface

Parameters:
- LOAD_LAT, default 1: number of cycles after issue before a load result can be forwarded; legal range 1..3; sets the depth of the load tracker.

Ports:
- CLK  input  1  clock; all state updates on rising edge
- nRST  input  1  reset, synchronous, active-low
- instr_i  input  32  instruction from IF/ID
- instr_valid_i  input  1  instr_i holds a real instruction
- stall_ext_i  input  1  downstream freeze (cache miss); stage holds everything
- flush_i  input  1  EX redirect (taken branch/jump); discard current instruction
- id_stall_o  output  1  combinational; IF/ID must hold instr_i this cycle
- iread_o  output  1  combinational; equals ~halted_o
- ex_valid_o  output  1  registered; ID/EX bundle is a real instruction
- rs_o, rt_o, rd_o  output  5 each  registered register specifiers
- imm_o  output  16  registered immediate
- shamt_o  output  5  registered shift amount
- ALUCtr  output  aluop_t  registered ALU operation
- ExtOp, ALUSrc, MemtoReg, RegWr, Jump, JR, JumpReg, LUI, dread, dwrite  output  1 each  registered controls
- RegDst  output  2  0=rt, 1=rd, 2=$31
- Branch  output  2  0=none, 1=BEQ, 2=BNE; resolved in EX
- LDsel, SVsel  output  2 each  0=word, 1=byte, 2=halfword
- illegal_o  output  1  registered one-cycle pulse for an unknown opcode/funct
- halted_o  output  1  registered, sticky until reset

## Operation

- Decode table: the existing single-cycle control semantics, with these changes. Branch is an encoded kind, not a resolved decision. RegDst for R-type is 2'd1. iread/halt are replaced by iread_o/halted_o.
- Source use: rs is read by R-type ALU ops, SLLV/SRLV, JR, branches, immediate ALU ops, loads and stores. rt is read by R-type, branches and stores. J, JAL, LUI and HALT read neither.
- Load tracker: LOAD_LAT entries {v, dst}. Entry 0 = youngest. Advances only when stall_ext_i=0. New entry 0 = {issued instr is a load, its rt}; bubbles and flushes insert v=0.
- Load-use hazard: instr_valid_i and a used source matches a tracker entry with v=1 and dst≠0. Register 0 never hazards.
- Per-cycle priority, highest first:
  1. nRST=0: all registered outputs and the tracker clear.
  2. stall_ext_i=1: all state holds; id_stall_o=1.
  3. flush_i=1: issue a bubble; id_stall_o=0 so IF loads the redirect target; no hazard stall; HALT is not latched.
  4. halted_o=1: issue a bubble; id_stall_o=1.
  5. Hazard: issue a bubble; id_stall_o=1.
  6. Otherwise issue the decode of instr_i; ex_valid_o=instr_valid_i. HALT issues as a bubble and sets halted_o.
- Bubble: ex_valid_o=0 and every control 0. Specifiers/imm don't care, driven 0.
- Unknown opcode or funct: issued with all controls 0, ex_valid_o=1, illegal_o=1 for one cycle.

## Timing

- Decode latency: 1 cycle from instr_i to the registered bundle.
- id_stall_o and iread_o are combinational from the current inputs and state; no extra latency.
- Reset values:
  - all registered outputs 0; ALUCtr=ALU_SLL; Branch=0; halted_o=0
  - tracker all invalid
  - id_stall_o=0 (no valid tracker entries); iread_o=1
- Load-use stall length:
  - a dependent instruction directly behind a load stalls exactly LOAD_LAT cycles, absent stall_ext_i.
  - one independent instruction in between reduces the stall by 1.
- stall_ext_i cycles do not age the tracker and do not count toward the stall.
- Flush in the same cycle as a hazard: flush wins; the bubble still ages the tracker.
- halted_o rises the cycle after HALT issues; iread_o falls in that same cycle.

## Test plan

- Reset: hold nRST=0 with instr_i=ADDU $3,$1,$2 and valid -> after release, first edge gives ex_valid_o=1, ALUCtr=ALU_ADD, RegDst=1, RegWr=1, rd_o=3; reset values all 0 before that edge.
- Load-use, LOAD_LAT=2: LW $5,0($1) then ADDU $6,$5,$0 -> id_stall_o high for 2 cycles, two bubbles, ADDU issues on the third edge after LW. Repeat with $0 as the load destination -> no stall.
- External freeze: LW, then stall_ext_i=1 for 3 cycles during the hazard -> outputs frozen; stall still totals LOAD_LAT non-frozen cycles.
- Flush: ADDI in ID with flush_i=1 -> ex_valid_o=0 and RegWr=0 next cycle, id_stall_o=0. HALT in ID with flush_i=1 -> halted_o stays 0.
- HALT: issue HALT -> halted_o=1 and iread_o=0 next cycle. Subsequent valid instructions -> bubbles with id_stall_o=1 until nRST.
- Sizes/illegal: LBU -> LDsel=1, dread=1, MemtoReg=1. SH -> SVsel=2, dwrite=1. BNE -> Branch=2, ExtOp=1. Opcode 6'h3F -> illegal_o pulse, no writes.
